tx_rd_req_sched: RTL and testbench

Schedules host-memory read requests for the TX path: accepts chunk-read requests from two requesters (requester 0 is the huge-page chunk reader; requester 1 is a second TX queue), arbitrates round-robin, and emits one MemRd TLP per grant on the endpoint TRN transmit interface. Caps in-flight reads with an outstanding-request counter and tags each request with its source. Sits between the chunk-reader FSMs and the PCIe endpoint TX port, in the trn_clk domain.

---
 rtl/tx_rd_pkg.sv | 26 ++
 rtl/tx_rd_req_sched_rr_arb2.sv | 16 +
 rtl/tx_rd_req_sched.sv | 158 +++++++++++++++
 tb/tb_tx_rd_req_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_rd_pkg.sv
// Shared constants and types for the TX read-request scheduler.
// Covers TLP format/type codes, one-hot FSM states and the tag layout.
package tx_rd_pkg;

  localparam logic [6:0] MEMRD64 = 7'b01_00000;
  localparam logic [6:0] MEMRD32 = 7'b00_00000;

  localparam int TAG_CNT_W = 4;
  localparam int TAG_IDX_W = 1;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_QW0  = 4'b0010,
    S_QW1  = 4'b0100,
    S_ACK  = 4'b1000
  } state_t;

  // Tag carries the source requester so completions can be steered back.
  function automatic logic [7:0] make_tag(input logic [TAG_IDX_W-1:0] idx,
                                          input logic [TAG_CNT_W-1:0] cnt);
    return {3'b000, idx, cnt};
  endfunction

endpackage

// File: rtl/tx_rd_req_sched_rr_arb2.sv
// Two-way round-robin arbiter; purely combinational, the parent registers the result.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // On contention the requester that was not served last wins.
  always_comb begin
    valid = |req;
    if (req == 2'b11) grant = ~last_grant;
    else              grant = req[1];
  end

endmodule

// File: rtl/tx_rd_req_sched.sv
// Arbitrates two chunk-read requesters and emits one MemRd TLP per grant on the
// endpoint TRN transmit port, limiting the number of reads in flight.
module tx_rd_req_sched
  import tx_rd_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic        trn_tdst_dsc_n,
  input  logic [3:0]  trn_tbuf_av,
  input  logic [15:0] cfg_completer_id,
  input  logic        rd_req0,
  input  logic        rd_req1,
  input  logic [63:0] rd_addr0,
  input  logic [63:0] rd_addr1,
  input  logic [8:0]  rd_qwords0,
  input  logic [8:0]  rd_qwords1,
  output logic        rd_ack0,
  output logic        rd_ack1,
  input  logic        rd_done0,
  input  logic        rd_done1,
  output logic [7:0]  rd_tag
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t      state;
  logic [63:3] addr_q;
  logic        idx_q;
  logic        last_grant;
  logic [3:0]  tag_cnt;
  logic [3:0]  outstanding;

  logic        grant_idx;
  logic        grant_valid;
  logic [63:3] sel_addr;
  logic [8:0]  sel_qwords;
  logic        eligible;
  logic        issue;
  logic [1:0]  done_cnt;
  logic [4:0]  out_inc;
  logic [3:0]  out_next;
  logic [31:0] hdr_dw0;
  logic [31:0] hdr_dw1;
  logic        wide_q;
  logic [63:0] qw1_beat;
  logic        unused_bits;

  assign unused_bits = ^{trn_tbuf_av[3:1], rd_addr0[2:0], rd_addr1[2:0]};

  rr_arb2 u_arb (
    .req        ({rd_req1, rd_req0}),
    .last_grant (last_grant),
    .grant      (grant_idx),
    .valid      (grant_valid)
  );

  always_comb begin
    sel_addr   = grant_idx ? rd_addr1[63:3] : rd_addr0[63:3];
    sel_qwords = grant_idx ? rd_qwords1 : rd_qwords0;
    eligible   = grant_valid && (outstanding < MAX_OUT) && trn_tbuf_av[0];

    hdr_dw0 = {1'b0, (sel_addr[63:32] != 32'h0) ? MEMRD64 : MEMRD32,
               8'h00, 6'b000000, {sel_qwords, 1'b0}};
    hdr_dw1 = {cfg_completer_id, make_tag(grant_idx, tag_cnt), BE_ALL, BE_ALL};

    wide_q   = (addr_q[63:32] != 32'h0);
    qw1_beat = wide_q ? {addr_q[63:32], addr_q[31:3], 3'b000}
                      : {addr_q[31:3], 3'b000, 32'h0};

    // A discontinue overrides acceptance, so an aborted EOF is not an issue.
    issue    = (state == S_QW1) && trn_tdst_dsc_n && !trn_tdst_rdy_n;
    done_cnt = {1'b0, rd_done0} + {1'b0, rd_done1};
    out_inc  = {1'b0, outstanding} + {4'b0000, issue};
    out_next = (out_inc < {3'b000, done_cnt}) ? 4'd0
                                             : 4'(out_inc - {3'b000, done_cnt});
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      trn_td         <= '0;
      trn_trem_n     <= 8'h00;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
      rd_ack0        <= 1'b0;
      rd_ack1        <= 1'b0;
      rd_tag         <= 8'h00;
      addr_q         <= '0;
      idx_q          <= 1'b0;
      last_grant     <= 1'b1;
      tag_cnt        <= 4'd0;
      outstanding    <= 4'd0;
    end else begin
      outstanding <= out_next;
      case (state)
        S_IDLE: begin
          if (eligible) begin
            addr_q         <= sel_addr;
            idx_q          <= grant_idx;
            trn_td         <= {hdr_dw0, hdr_dw1};
            trn_trem_n     <= 8'h00;
            trn_tsof_n     <= 1'b0;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b0;
            state          <= S_QW0;
          end
        end
        S_QW0: begin
          if (!trn_tdst_dsc_n) begin
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            state          <= S_IDLE;
          end else if (!trn_tdst_rdy_n) begin
            trn_td     <= qw1_beat;
            trn_trem_n <= wide_q ? 8'h00 : 8'h0F;
            trn_tsof_n <= 1'b1;
            trn_teof_n <= 1'b0;
            state      <= S_QW1;
          end
        end
        S_QW1: begin
          if (!trn_tdst_dsc_n) begin
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            state          <= S_IDLE;
          end else if (!trn_tdst_rdy_n) begin
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            rd_ack0        <= ~idx_q;
            rd_ack1        <= idx_q;
            rd_tag         <= make_tag(idx_q, tag_cnt);
            tag_cnt        <= tag_cnt + 4'd1;
            last_grant     <= idx_q;
            state          <= S_ACK;
          end
        end
        S_ACK: begin
          rd_ack0 <= 1'b0;
          rd_ack1 <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_rd_req_sched.sv
// Directed self-checking bench for tx_rd_req_sched, built with a read cap of two
// so the outstanding limit is reachable in a short run.
module tb_tx_rd_req_sched;

  logic        trn_clk;
  logic        reset_n;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic        trn_tdst_dsc_n;
  logic [3:0]  trn_tbuf_av;
  logic [15:0] cfg_completer_id;
  logic        rd_req0;
  logic        rd_req1;
  logic [63:0] rd_addr0;
  logic [63:0] rd_addr1;
  logic [8:0]  rd_qwords0;
  logic [8:0]  rd_qwords1;
  logic        rd_ack0;
  logic        rd_ack1;
  logic        rd_done0;
  logic        rd_done1;
  logic [7:0]  rd_tag;

  int testsRun;
  int testsFailed;

  tx_rd_req_sched #(.MAX_OUTSTANDING(2)) dut (
    .trn_clk          (trn_clk),
    .reset_n          (reset_n),
    .trn_td           (trn_td),
    .trn_trem_n       (trn_trem_n),
    .trn_tsof_n       (trn_tsof_n),
    .trn_teof_n       (trn_teof_n),
    .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n   (trn_tdst_rdy_n),
    .trn_tdst_dsc_n   (trn_tdst_dsc_n),
    .trn_tbuf_av      (trn_tbuf_av),
    .cfg_completer_id (cfg_completer_id),
    .rd_req0          (rd_req0),
    .rd_req1          (rd_req1),
    .rd_addr0         (rd_addr0),
    .rd_addr1         (rd_addr1),
    .rd_qwords0       (rd_qwords0),
    .rd_qwords1       (rd_qwords1),
    .rd_ack0          (rd_ack0),
    .rd_ack1          (rd_ack1),
    .rd_done0         (rd_done0),
    .rd_done1         (rd_done1),
    .rd_tag           (rd_tag)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] obs,
                             input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic [63:0] a0, input logic [8:0] q0,
                               input logic r1, input logic [63:0] a1, input logic [8:0] q1);
    rd_req0    = r0;
    rd_addr0   = a0;
    rd_qwords0 = q0;
    rd_req1    = r1;
    rd_addr1   = a1;
    rd_qwords1 = q1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 64'h0, 9'd1, 1'b0, 64'h0, 9'd1);
    trn_tdst_rdy_n = 1'b0;
    trn_tdst_dsc_n = 1'b1;
    trn_tbuf_av    = 4'hF;
    rd_done0       = 1'b0;
    rd_done1       = 1'b0;
    reset_n        = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Walks one TLP from SOF through ack, checking each beat and the ack cycle.
  task automatic runTlp(input logic idx, input logic [63:0] qw0, input logic [63:0] qw1,
                        input logic [7:0] trem1, input logic [7:0] tag, input logic keepReq);
    tick();
    checkOutput("sof_td", trn_td, qw0);
    checkOutput("sof_ctl", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n}, {3'b010, 8'h00});
    tick();
    checkOutput("eof_td", trn_td, qw1);
    checkOutput("eof_ctl", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n}, {3'b100, trem1});
    tick();
    checkOutput("ack", {rd_ack1, rd_ack0, trn_tsrc_rdy_n}, {idx, ~idx, 1'b1});
    checkOutput("tag", rd_tag, tag);
    if (!keepReq) begin
      if (idx) rd_req1 = 1'b0;
      else     rd_req0 = 1'b0;
    end
    tick();
    checkOutput("ack_clr", {rd_ack1, rd_ack0}, 2'b00);
  endtask

  initial begin
    testsRun         = 0;
    testsFailed      = 0;
    cfg_completer_id = 16'hABCD;
    doReset();

    checkOutput("rst_td", trn_td, 64'h0);
    checkOutput("rst_ctl", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n}, {3'b111, 8'h00});
    checkOutput("rst_ack_tag", {rd_ack1, rd_ack0, rd_tag}, 10'h000);

    // 4DW read, 64 qwords
    applyStimulus(1'b1, 64'h0000_0001_0000_2000, 9'd64, 1'b0, 64'h0, 9'd1);
    runTlp(1'b0, 64'h2000_0080_ABCD_00FF, 64'h0000_0001_0000_2000, 8'h00, 8'h00, 1'b0);

    // 3DW read, 16 qwords
    applyStimulus(1'b1, 64'h0000_0000_8000_0040, 9'd16, 1'b0, 64'h0, 9'd1);
    runTlp(1'b0, 64'h0000_0020_ABCD_01FF, 64'h8000_0040_0000_0000, 8'h0F, 8'h01, 1'b0);

    // Two reads in flight: the third waits for a completion
    applyStimulus(1'b0, 64'h0, 9'd1, 1'b1, 64'h0000_0000_0000_1000, 9'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("cap_stall", trn_tsrc_rdy_n, 1'b1);
    end
    rd_done0 = 1'b1;
    tick();
    rd_done0 = 1'b0;
    checkOutput("cap_stall_done", trn_tsrc_rdy_n, 1'b1);
    runTlp(1'b1, 64'h0000_0002_ABCD_12FF, 64'h0000_1000_0000_0000, 8'h0F, 8'h12, 1'b0);

    // Both requesters held: grants alternate starting with requester 0
    doReset();
    rd_done0 = 1'b1;
    applyStimulus(1'b1, 64'h0000_0000_0000_0100, 9'd2, 1'b1, 64'h0000_0000_0000_0200, 9'd4);
    runTlp(1'b0, 64'h0000_0004_ABCD_00FF, 64'h0000_0100_0000_0000, 8'h0F, 8'h00, 1'b1);
    runTlp(1'b1, 64'h0000_0008_ABCD_11FF, 64'h0000_0200_0000_0000, 8'h0F, 8'h11, 1'b1);
    runTlp(1'b0, 64'h0000_0004_ABCD_02FF, 64'h0000_0100_0000_0000, 8'h0F, 8'h02, 1'b1);
    runTlp(1'b1, 64'h0000_0008_ABCD_13FF, 64'h0000_0200_0000_0000, 8'h0F, 8'h13, 1'b1);
    applyStimulus(1'b0, 64'h0, 9'd1, 1'b0, 64'h0, 9'd1);
    rd_done0 = 1'b0;

    // Back-pressure on the EOF beat; low address bits are ignored
    applyStimulus(1'b1, 64'h0000_0002_0000_300F, 9'd8, 1'b0, 64'h0, 9'd1);
    tick();
    checkOutput("bp_sof_td", trn_td, 64'h2000_0010_ABCD_04FF);
    tick();
    checkOutput("bp_eof_td", trn_td, 64'h0000_0002_0000_3008);
    trn_tdst_rdy_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hold_td", trn_td, 64'h0000_0002_0000_3008);
      checkOutput("bp_hold_ctl", {rd_ack0, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n},
                  {4'b0100, 8'h00});
    end
    trn_tdst_rdy_n = 1'b0;
    tick();
    checkOutput("bp_ack", {rd_ack1, rd_ack0, rd_tag}, {2'b01, 8'h04});
    rd_req0 = 1'b0;
    tick();

    // Discontinue during SOF: no ack, tag untouched, same request reissued
    applyStimulus(1'b1, 64'h0000_0000_0000_4000, 9'd1, 1'b0, 64'h0, 9'd1);
    tick();
    checkOutput("dsc_sof_td", trn_td, 64'h0000_0002_ABCD_05FF);
    trn_tdst_dsc_n = 1'b0;
    tick();
    trn_tdst_dsc_n = 1'b1;
    checkOutput("dsc_abort", {rd_ack1, rd_ack0, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}, 5'b00111);
    checkOutput("dsc_tag", rd_tag, 8'h04);
    runTlp(1'b0, 64'h0000_0002_ABCD_05FF, 64'h0000_4000_0000_0000, 8'h0F, 8'h05, 1'b0);

    // No non-posted credit: request waits until credit returns
    rd_done0 = 1'b1;
    rd_done1 = 1'b1;
    tick();
    rd_done0    = 1'b0;
    rd_done1    = 1'b0;
    trn_tbuf_av = 4'hE;
    applyStimulus(1'b0, 64'h0, 9'd1, 1'b1, 64'h0000_0000_0000_5000, 9'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("credit_stall", trn_tsrc_rdy_n, 1'b1);
    end
    trn_tbuf_av = 4'hF;
    runTlp(1'b1, 64'h0000_0006_ABCD_16FF, 64'h0000_5000_0000_0000, 8'h0F, 8'h16, 1'b0);

    // Reset in the middle of a packet
    applyStimulus(1'b1, 64'h0000_0000_0000_6000, 9'd1, 1'b0, 64'h0, 9'd1);
    tick();
    tick();
    checkOutput("mid_eof", {trn_teof_n, trn_tsrc_rdy_n}, 2'b00);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_td", trn_td, 64'h0);
    checkOutput("mid_rst_ctl", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_trem_n}, {3'b111, 8'h00});
    checkOutput("mid_rst_ack_tag", {rd_ack1, rd_ack0, rd_tag}, 10'h000);
    rd_req0 = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("post_rst_idle", trn_tsrc_rdy_n, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
